// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and constants for the stream round-robin arbiter:
// FSM state encoding, counter width and index-width helper.
package stream_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int CNT_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of N_IN requester streams plus the single shared output stream.
// slave = arbiter view, master = environment driving requesters and sink.
interface stream_rr_arbiter_if #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 32
);
    logic [N_IN-1:0]             in_tvalid;
    logic [N_IN-1:0]             in_tlast;
    logic [N_IN-1:0][DATA_W-1:0] in_tdata;
    logic [N_IN-1:0]             in_tready;
    logic                        out_tvalid;
    logic                        out_tlast;
    logic [DATA_W-1:0]           out_tdata;
    logic                        out_tready;
    logic [N_IN-1:0]             grant;

    modport slave (
        input  in_tvalid, in_tlast, in_tdata, out_tready,
        output in_tready, out_tvalid, out_tlast, out_tdata, grant
    );

    modport master (
        output in_tvalid, in_tlast, in_tdata, out_tready,
        input  in_tready, out_tvalid, out_tlast, out_tdata, grant
    );
endinterface

// File: rtl/stream_rr_arbiter_rr_select.sv
// Combinational rotating-priority select: first requester at or after
// ptr_i, wrapping N_IN-1 -> 0; returns both one-hot and binary index.
module rr_select
    import stream_arb_pkg::*;
#(
    parameter  int N_IN  = 4,
    localparam int IDX_W = idx_w(N_IN)
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_IN-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_IN; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N_IN);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin stream arbiter (IDLE/BUSY, one bubble per packet).
// Define STREAM_ARB_PMU_EN to add per-input packet counters and a stall counter.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stream_rr_arbiter_if.slave        bus
`ifdef STREAM_ARB_PMU_EN
    ,
    output logic [N_IN-1:0][CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]           stall_cnt
`endif
);

    localparam int IDX_W = idx_w(N_IN);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic [N_IN-1:0]  sel_gnt;
    logic [IDX_W-1:0] sel_idx;
    logic             beat;
    logic             last_beat;

    rr_select #(.N_IN(N_IN)) u_sel (
        .req_i (bus.in_tvalid),
        .ptr_i (ptr_q),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx)
    );

    // Output mux is purely combinational so a beat costs no latency once granted.
    always_comb begin
        bus.out_tvalid = 1'b0;
        bus.out_tlast  = 1'b0;
        bus.out_tdata  = '0;
        bus.in_tready  = '0;
        if (state_q == BUSY) begin
            bus.out_tvalid = bus.in_tvalid[gidx_q];
            bus.out_tlast  = bus.in_tlast[gidx_q];
            bus.out_tdata  = bus.in_tdata[gidx_q];
            bus.in_tready  = grant_q & {N_IN{bus.out_tready}};
        end
    end

    assign bus.grant = grant_q;
    assign beat      = bus.out_tvalid & bus.out_tready;
    assign last_beat = beat & bus.out_tlast;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.in_tvalid) begin
                    state_d = BUSY;
                    grant_d = sel_gnt;
                    gidx_d  = sel_idx;
                end
            end
            BUSY: begin
                // Ownership ends only on a transferred tlast, never on tvalid dropping.
                if (last_beat) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == IDX_W'(N_IN - 1)) ? '0 : gidx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
        end
    end

`ifdef STREAM_ARB_PMU_EN
    logic [N_IN-1:0][CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0]           stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (last_beat) begin
                pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + CNT_W'(1);
            end
            if (bus.out_tvalid && !bus.out_tready) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: directed packets per input, expected
// beats queued at issue time, a negedge monitor pops and compares each transfer.
module tb_stream_rr_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    beat_t      src_q[4][$];
    exp_t       sb[$];
    logic [3:0] hold;

    stream_rr_arbiter_if #(.N_IN(4), .DATA_W(32)) bus ();

`ifdef STREAM_ARB_PMU_EN
    logic [3:0][31:0] pkt_cnt;
    logic [31:0]      stall_cnt;
`endif

    stream_rr_arbiter #(.N_IN(4), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef STREAM_ARB_PMU_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transferred beat must match the head of the scoreboard.
    exp_t       mon_e;
    logic [3:0] mon_oh;
    always @(negedge clk) begin
        if (rst_n && bus.out_tvalid && bus.out_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h expected no beat at %0t", bus.out_tdata, $time);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 4'b0001 << mon_e.idx;
                check("beat_data",  64'(bus.out_tdata), 64'(mon_e.data));
                check("beat_last",  64'(bus.out_tlast), 64'(mon_e.last));
                check("beat_grant", 64'(bus.grant),     64'(mon_oh));
            end
        end
    end

    function automatic void drive();
        logic [3:0]       v;
        logic [3:0]       l;
        logic [3:0][31:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() != 0 && !hold[i]) begin
                v[i] = 1'b1;
                d[i] = src_q[i][0].data;
                l[i] = src_q[i][0].last;
            end
        end
        bus.in_tvalid = v;
        bus.in_tlast  = l;
        bus.in_tdata  = d;
    endfunction

    // Handshakes are sampled at negedge and consumed just after the following posedge.
    task automatic tick();
        logic [3:0] fired;
        @(negedge clk);
        fired = rst_n ? (bus.in_tvalid & bus.in_tready) : 4'b0000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fired[i]) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic load(input int idx, input logic [31:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[idx].push_back(b);
    endtask

    task automatic send(input int idx, input logic [31:0] data, input logic last);
        exp_t e;
        load(idx, data, last);
        e.idx  = idx;
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [3:0] exp_g;
        checks         = 0;
        errors         = 0;
        hold           = '0;
        rst_n          = 1'b0;
        bus.out_tready = 1'b1;
        drive();

        // Reset with every input requesting: nothing may leak out.
        send(0, 32'h100, 1'b1);
        send(1, 32'h101, 1'b1);
        send(2, 32'h102, 1'b1);
        send(3, 32'h103, 1'b1);
        send(0, 32'h104, 1'b1);
        drive();
        tick();
        tick();
        check("rst_grant",      64'(bus.grant),      64'd0);
        check("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("rst_in_tready",  64'(bus.in_tready),  64'd0);
`ifdef STREAM_ARB_PMU_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;

        // All single-beat, all valid: 0001,0,0010,0,0100,0,1000,0,0001,0.
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_g = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
            check("rr_grant",      64'(bus.grant),      64'(exp_g));
            check("rr_in_tready",  64'(bus.in_tready),  64'(exp_g));
            check("rr_out_tvalid", 64'(bus.out_tvalid), 64'(k % 2));
        end

        // Input 2 three-beat packet while input 0 waits (ptr = 1).
        send(2, 32'hA, 1'b0);
        send(2, 32'hB, 1'b0);
        send(2, 32'hC, 1'b1);
        send(0, 32'h100, 1'b1);
        drive();
        tick(); check("pkt_grant_1", 64'(bus.grant), 64'b0100);
        tick(); check("pkt_grant_2", 64'(bus.grant), 64'b0100);
        tick(); check("pkt_grant_3", 64'(bus.grant), 64'b0100);
        tick(); check("pkt_grant_4", 64'(bus.grant), 64'b0000);
        tick(); check("pkt_grant_5", 64'(bus.grant), 64'b0001);
        tick(); check("pkt_grant_6", 64'(bus.grant), 64'b0000);

        // Owner (input 3) drops tvalid for two cycles; input 1 must wait.
        send(3, 32'h30, 1'b0);
        send(3, 32'h31, 1'b0);
        send(3, 32'h32, 1'b1);
        drive();
        tick(); check("gap_grant_1", 64'(bus.grant), 64'b1000);
        tick(); check("gap_grant_2", 64'(bus.grant), 64'b1000);
        hold[3] = 1'b1;
        send(1, 32'h10, 1'b1);
        drive();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("gap_hold_grant",  64'(bus.grant),      64'b1000);
            check("gap_hold_tvalid", 64'(bus.out_tvalid), 64'd0);
            check("gap_hold_tready", 64'(bus.in_tready),  64'b1000);
        end
        hold[3] = 1'b0;
        drive();
        tick(); check("gap_grant_5", 64'(bus.grant), 64'b1000);
        tick(); check("gap_grant_6", 64'(bus.grant), 64'b0000);
        tick(); check("gap_grant_7", 64'(bus.grant), 64'b0010);
        tick(); check("gap_grant_8", 64'(bus.grant), 64'b0000);

        // Backpressure: five BUSY cycles with out_tready low on input 2.
        bus.out_tready = 1'b0;
        send(2, 32'h20, 1'b0);
        send(2, 32'h21, 1'b1);
        drive();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_grant",  64'(bus.grant),      64'b0100);
            check("stall_data",   64'(bus.out_tdata),  64'h20);
            check("stall_tvalid", 64'(bus.out_tvalid), 64'd1);
            check("stall_tready", 64'(bus.in_tready),  64'd0);
            tick();
        end
`ifdef STREAM_ARB_PMU_EN
        check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        bus.out_tready = 1'b1;
        tick();
        tick(); check("stall_done_grant", 64'(bus.grant), 64'b0000);

        // Reset mid-packet from input 3; afterwards ptr must be back at 0.
        send(3, 32'h40, 1'b0);
        load(3, 32'h41, 1'b0);
        load(3, 32'h42, 1'b1);
        drive();
        tick(); check("mid_grant_1", 64'(bus.grant), 64'b1000);
        tick(); check("mid_grant_2", 64'(bus.grant), 64'b1000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant",  64'(bus.grant),      64'd0);
        check("mid_rst_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("mid_rst_tready", 64'(bus.in_tready),  64'd0);
        src_q[3].delete();
        send(0, 32'h50, 1'b1);
        send(3, 32'h70, 1'b1);
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        tick(); check("post_rst_grant_1", 64'(bus.grant), 64'b0001);
        tick(); check("post_rst_grant_2", 64'(bus.grant), 64'b0000);
        tick(); check("post_rst_grant_3", 64'(bus.grant), 64'b1000);
        tick(); check("post_rst_grant_4", 64'(bus.grant), 64'b0000);
        wait_drain("drain_before_pmu", 20);

        // Three packets from input 3 only, counted from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send(3, 32'h80, 1'b0);
        send(3, 32'h81, 1'b1);
        send(3, 32'h82, 1'b1);
        send(3, 32'h83, 1'b1);
        drive();
        wait_drain("drain_pmu", 40);
`ifdef STREAM_ARB_PMU_EN
        check("pkt_cnt_0", 64'(pkt_cnt[0]), 64'd0);
        check("pkt_cnt_1", 64'(pkt_cnt[1]), 64'd0);
        check("pkt_cnt_2", 64'(pkt_cnt[2]), 64'd0);
        check("pkt_cnt_3", 64'(pkt_cnt[3]), 64'd3);
`endif
        tick();
        check("final_grant", 64'(bus.grant), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of requesting stream inputs (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, TDATA width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_tvalid/in_tlast  input  N_IN  per-requester valid/last.
REQ-006 SHALL have port in_tdata  input  N_IN x DATA_W  per-requester data, packed array.
REQ-007 SHALL have port in_tready  output  N_IN  per-requester ready.
REQ-008 SHALL have ports out_tvalid/out_tlast  output  1, out_tdata  output  DATA_W, out_tready  input  1, toward the shared queue.
REQ-009 SHALL have port grant  output  N_IN  one-hot current owner, zero when idle.

Function
REQ-010 SHALL implement FSM with states IDLE and BUSY.
REQ-011 In IDLE, any in_tvalid high SHALL select the first valid index at or after ptr, scanning upward with wrap N_IN-1 -> 0, then latch grant and enter BUSY next cycle.
REQ-012 In IDLE, out_tvalid and all in_tready SHALL be 0; no beat transfers (one-cycle arbitration bubble per packet).
REQ-013 In BUSY, out_tvalid/out_tdata/out_tlast SHALL combinationally equal the granted input; in_tready[grant] = out_tready; every other in_tready = 0.
REQ-014 A beat SHALL transfer only when out_tvalid and out_tready are both high in the same cycle.
REQ-015 Grant SHALL hold until a beat with tlast transfers, regardless of the owner dropping tvalid mid-packet.
REQ-016 On tlast transfer, SHALL return to IDLE and set ptr = grant index + 1 modulo N_IN.
REQ-017 Single active requester SHALL win every packet, one bubble cycle between packets.
REQ-018 All requesters continuously valid SHALL be served in order 0,1,...,N_IN-1,0.
REQ-019 Single-beat packet (tlast on first beat) SHALL occupy exactly one BUSY cycle when out_tready is high.

Reset
REQ-020 Reset SHALL force IDLE, ptr = 0, grant = 0, out_tvalid = 0, in_tready = 0, asynchronously, including mid-packet; the partial packet is abandoned.
REQ-021 After reset deassertion, first arbitration SHALL occur on the first clock edge with any in_tvalid high.

Configuration
REQ-022 Macro STREAM_ARB_PMU_EN SHALL compile in per-input packet counters pkt_cnt (output, N_IN x 32) and stall counter stall_cnt (output, 32).
REQ-023 With STREAM_ARB_PMU_EN: pkt_cnt[i] +1 on each tlast transfer from input i; stall_cnt +1 each cycle out_tvalid && !out_tready; both wrap at 2^32, reset to 0.
REQ-024 Without STREAM_ARB_PMU_EN: ports and counter logic SHALL be absent; arbitration behaviour identical.

Structure
REQ-025 Shared package stream_arb_pkg SHALL hold the FSM state enum, counter width constant (32) and the index-width helper.
REQ-026 Rotating priority select SHALL be sub-module rr_select (inputs request vector, ptr; output one-hot and index, combinational).

Verification
REQ-027 Reset, in_tvalid=4'b1111 all single-beat, out_tready=1 -> grant sequence 0001,0010,0100,1000,0001, one bubble between each.
REQ-028 Input 2 sends 3-beat packet 0xA,0xB,0xC(last) while input 0 valid -> out_tdata A,B,C uninterrupted, then grant 0001.
REQ-029 Owner drops tvalid 2 cycles mid-packet, input 1 valid -> grant unchanged, no beats from input 1 until owner's tlast.
REQ-030 out_tready held 0 for 5 cycles in BUSY -> out_tdata stable, in_tready[grant]=0; with PMU, stall_cnt=5.
REQ-031 rst_n asserted mid-packet -> same cycle out_tvalid=0, grant=0; after release, input 0 wins first (ptr=0).
REQ-032 PMU build, 3 packets from input 3 -> pkt_cnt[3]=3, others 0; non-PMU build passes REQ-027..031 unchanged.
